mem_access_stage: RTL and testbench

Memory (MEM) stage of the 5-stage ARM pipeline. It sits between the EX/MEM and MEM/WB boundaries and consumes the EX/MEM control bits (load/store, load, size, RF enable) together with the address and store data. It drives a variable-latency data-memory port with a req/ack handshake and stalls the upstream pipeline until the access completes. It also owns the MEM/WB register: it selects the ALU result or the lane-aligned load data for write-back.

---
 rtl/arm_pipe_pkg.sv | 7 +
 rtl/mem_lane_align.sv | 25 ++
 rtl/mem_access_stage.sv | 96 +++++++++
 tb/tb_mem_access_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared MEM-stage FSM states, byte-enable constants and size encoding
package arm_pipe_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  localparam logic [3:0] BE_WORD   = 4'b1111;
  localparam logic [3:0] BE_B0     = 4'b1000;
  localparam logic       SIZE_WORD = 1'b1;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane steering for stores and lane extraction for loads
// Ports: i_size (1=word), i_offset (addr[1:0]), i_store_data, i_rdata in;
//        o_be, o_wdata (store side), o_load_data (zero-extended load value) out.
module mem_lane_align
  import arm_pipe_pkg::*;
(
  input  logic        i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);
  logic        w_word;
  logic [31:0] w_shifted;
  // offset 0 lives in bits 31:24, so shift right by 8*(3-offset)
  assign w_word    = i_size == SIZE_WORD;
  assign w_shifted = i_rdata >> {~i_offset, 3'b000};
  always_comb begin
    o_be        = w_word ? BE_WORD : BE_B0 >> i_offset;
    o_wdata     = w_word ? i_store_data : {4{i_store_data[7:0]}};
    o_load_data = w_word ? i_rdata : {24'h0, w_shifted[7:0]};
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with req/ack data-memory port, stall/timeout FSM and MEM/WB register
// Ports: Clk, Reset (async active-low); MEM_* EX/MEM control, address and store data in;
//        dm_* data-memory handshake; mem_stall/mem_fault/mem_misalign status; WB_* registered MEM/WB.
module mem_access_stage
  import arm_pipe_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MEM_load_store_instr,
  input  logic              MEM_load_instr,
  input  logic              MEM_size,
  input  logic              MEM_RF_enable,
  input  logic [3:0]        MEM_rd,
  input  logic [31:0]       MEM_alu_result,
  input  logic [31:0]       MEM_store_data,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic              mem_misalign,
  output logic              WB_RF_enable,
  output logic              WB_load_instr,
  output logic [3:0]        WB_rd,
  output logic [31:0]       WB_data
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wb_rf, r_wb_ld;
  logic [3:0]    r_wb_rd;
  logic [31:0]   r_wb_data;
  logic          w_word, w_idle_req, w_wait, w_timeout, w_is_load;
  logic [31:0]   w_load_data;
  mem_lane_align u_align (
    .i_size      (MEM_size),
    .i_offset    (MEM_alu_result[1:0]),
    .i_store_data(MEM_store_data),
    .i_rdata     (dm_rdata),
    .o_be        (dm_be),
    .o_wdata     (dm_wdata),
    .o_load_data (w_load_data)
  );
  assign w_word     = MEM_size == SIZE_WORD;
  assign w_wait     = r_state == WAIT;
  assign w_idle_req = (r_state == IDLE) & MEM_load_store_instr;
  // r_cnt holds the index of the current WAIT cycle; a late ack on the last one still wins
  assign w_timeout  = w_wait & (r_cnt == TO_C) & ~dm_ack;
  assign w_is_load  = MEM_load_store_instr & MEM_load_instr;
  assign dm_req       = w_idle_req | (w_wait & ~w_timeout);
  assign dm_we        = dm_req & ~MEM_load_instr;
  assign dm_addr      = {MEM_alu_result[ADDR_W-1:2], w_word ? 2'b00 : MEM_alu_result[1:0]};
  assign mem_stall    = dm_req & ~dm_ack;
  assign mem_fault    = w_timeout;
  // reported once, in the first cycle of the access
  assign mem_misalign = w_idle_req & w_word & |MEM_alu_result[1:0];
  assign WB_RF_enable  = r_wb_rf;
  assign WB_load_instr = r_wb_ld;
  assign WB_rd         = r_wb_rd;
  assign WB_data       = r_wb_data;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (!w_wait) begin
      r_state <= mem_stall ? WAIT : IDLE;
      r_cnt   <= mem_stall ? CW'(1) : '0;
    end else begin
      r_state <= (dm_ack | w_timeout) ? IDLE : WAIT;
      r_cnt   <= (dm_ack | w_timeout) ? '0 : r_cnt + 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wb_rf   <= 1'b0;
      r_wb_ld   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (mem_stall) begin
      r_wb_rf   <= 1'b0;
    end else begin
      r_wb_rf   <= MEM_RF_enable & ~w_timeout;
      r_wb_ld   <= MEM_load_instr;
      r_wb_rd   <= MEM_rd;
      r_wb_data <= w_is_load ? w_load_data : MEM_alu_result;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench against a byte-array memory model
module tb_mem_access_stage;
  localparam int TO = 15;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls, ld, sz, rf;
  logic [3:0]  rd;
  logic [31:0] alu, sd;
  logic        dm_req, dm_we, dm_ack;
  logic [7:0]  dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata, dm_rdata;
  logic        mem_stall, mem_fault, mem_misalign;
  logic        wb_rf, wb_ld;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [7:0]  mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .Clk(clk), .Reset(rst_n),
    .MEM_load_store_instr(ls), .MEM_load_instr(ld), .MEM_size(sz), .MEM_RF_enable(rf),
    .MEM_rd(rd), .MEM_alu_result(alu), .MEM_store_data(sd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .mem_fault(mem_fault), .mem_misalign(mem_misalign),
    .WB_RF_enable(wb_rf), .WB_load_instr(wb_ld), .WB_rd(wb_rd), .WB_data(wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
  endfunction

  // one instruction through MEM; n = wait cycles before ack, n < 0 = memory never answers
  task automatic run(input bit i_ls, input bit i_ld, input bit i_sz, input bit i_rf,
                     input logic [3:0] i_rd, input logic [31:0] i_alu, input logic [31:0] i_sd,
                     input int n);
    logic [7:0]  a, aa;
    logic [3:0]  ebe;
    logic [31:0] ewd, eload;
    bit mis, to, done;
    int k;
    a     = i_alu[7:0];
    aa    = i_sz ? {a[7:2], 2'b00} : a;
    ebe   = i_sz ? 4'hF : 4'(1 << (3 - int'(a[1:0])));
    ewd   = i_sz ? i_sd : {4{i_sd[7:0]}};
    mis   = i_ls && i_sz && a[1:0] != 2'b00;
    eload = i_sz ? word_at(a) : {24'h0, mem[a]};
    to    = 0;
    k     = 0;
    @(negedge clk);
    ls = i_ls; ld = i_ld; sz = i_sz; rf = i_rf; rd = i_rd; alu = i_alu; sd = i_sd;
    dm_ack   = i_ls ? (n == 0) : 1'($urandom_range(0, 1));
    dm_rdata = (i_ls && i_ld && dm_ack) ? word_at(a) : $urandom;
    while (1) begin
      #1;
      to   = i_ls && n < 0 && k == TO;
      done = !i_ls || k == n || to;
      chk("dm_req", dm_req, i_ls && !to);
      chk("mem_stall", mem_stall, !done);
      chk("mem_fault", mem_fault, to);
      chk("mem_misalign", mem_misalign, mis && k == 0);
      if (i_ls && !to) begin
        chk("dm_addr", dm_addr, aa);
        chk("dm_be", dm_be, ebe);
        chk("dm_we", dm_we, !i_ld);
        if (!i_ld) chk("dm_wdata", dm_wdata, ewd);
      end
      if (done) break;
      @(posedge clk);
      #1;
      chk("bubble_rf", wb_rf, 0);
      @(negedge clk);
      k++;
      dm_ack   = (k == n);
      dm_rdata = (i_ld && dm_ack) ? word_at(a) : $urandom;
    end
    if (i_ls && !i_ld && !to) begin
      if (i_sz) for (int i = 0; i < 4; i++) mem[aa + 8'(i)] = i_sd[31 - 8*i -: 8];
      else mem[a] = i_sd[7:0];
    end
    @(posedge clk);
    #1;
    chk("wb_rf", wb_rf, i_rf && !to);
    chk("wb_rd", wb_rd, i_rd);
    chk("wb_ld", wb_ld, i_ld);
    if (!to) chk("wb_data", wb_data, (i_ls && i_ld) ? eload : i_alu);
  endtask

  initial begin
    int n;
    bit r_ls;
    rst_n = 1'b1;
    ls = 0; ld = 0; sz = 0; rf = 0; rd = 0; alu = 0; sd = 0;
    dm_ack = 0; dm_rdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #2 rst_n = 1'b0;
    #2;
    chk("rst_req", dm_req, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_misalign", mem_misalign, 0);
    chk("rst_wb_rf", wb_rf, 0);
    chk("rst_wb_ld", wb_ld, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 1, 0, 4'h0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    run(1, 1, 1, 1, 4'h1, 32'h0000_0010, 32'h0, 1);
    run(1, 0, 1, 0, 4'h0, 32'h0000_0010, 32'h1122_3344, 0);
    run(1, 1, 0, 1, 4'h3, 32'h0000_0013, 32'h0, 3);
    run(1, 0, 0, 0, 4'h0, 32'h0000_0021, 32'h0000_00AB, 2);
    run(1, 1, 1, 1, 4'h4, 32'h0000_0020, 32'h0, 0);
    run(1, 1, 1, 1, 4'h7, 32'h0000_0040, 32'h0, -1);
    run(0, 0, 0, 1, 4'h8, 32'h0BAD_F00D, 32'h0, 0);
    run(1, 1, 1, 1, 4'h2, 32'h0000_0006, 32'h0, 1);
    run(0, 0, 0, 1, 4'h9, 32'hCAFE_F00D, 32'h0, 0);
    run(0, 0, 0, 1, 4'h5, 32'h1234_5678, 32'h0, 0);
    @(negedge clk);
    ls = 1; ld = 1; sz = 1; rf = 1; rd = 4'h6; alu = 32'h80; dm_ack = 0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0; ls = 0; ld = 0; rf = 0;
    #1;
    chk("arst_req", dm_req, 0);
    chk("arst_stall", mem_stall, 0);
    chk("arst_wb_rf", wb_rf, 0);
    chk("arst_wb_ld", wb_ld, 0);
    chk("arst_wb_rd", wb_rd, 0);
    chk("arst_wb_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1, 1, 1, 4'hA, 32'h0000_0084, 32'h0, 0);
    for (int t = 0; t < 200; t++) begin
      r_ls = $urandom_range(0, 3) != 0;
      n = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
      run(r_ls, r_ls && $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
